// File: rtl/img2col_weight_pp_if.sv
// -----------------------------------------------------------------------------
// img2col_weight_pp_if
// Bundles the control handshake, configuration and weight-buffer traffic of the
// weight-side img2col engine.
//   master : control / buffer side (drives start, config and wgt_in)
//   slave  : the engine (drives status, read/write strobes, addresses, data)
// Signals:
//   i2c_wgt_start, i2c_chn_sel, chn_num, kernel_size, flip  - start + config
//   i2c_ready, i2c_done, i2c_err, chn_sel                   - status
//   wgt_rd_en, wgt_rd_addr, wgt_in                          - buffer read side
//   wgt_wr_en, wgt_wr_addr, wgt_out                         - matrix write side
// -----------------------------------------------------------------------------
interface img2col_weight_pp_if #(
    parameter int DATA_WID = 16,
    parameter int AW       = 8
);
    logic                i2c_wgt_start;
    logic                i2c_chn_sel;
    logic [7:0]          chn_num;
    logic [3:0]          kernel_size;
    logic                flip;
    logic [DATA_WID-1:0] wgt_in;
    logic                i2c_ready;
    logic                i2c_done;
    logic                i2c_err;
    logic                wgt_rd_en;
    logic [AW-1:0]       wgt_rd_addr;
    logic                wgt_wr_en;
    logic [AW-1:0]       wgt_wr_addr;
    logic [DATA_WID-1:0] wgt_out;
    logic                chn_sel;

    modport master (
        output i2c_wgt_start, i2c_chn_sel, chn_num, kernel_size, flip, wgt_in,
        input  i2c_ready, i2c_done, i2c_err, wgt_rd_en, wgt_rd_addr,
               wgt_wr_en, wgt_wr_addr, wgt_out, chn_sel
    );

    modport slave (
        input  i2c_wgt_start, i2c_chn_sel, chn_num, kernel_size, flip, wgt_in,
        output i2c_ready, i2c_done, i2c_err, wgt_rd_en, wgt_rd_addr,
               wgt_wr_en, wgt_wr_addr, wgt_out, chn_sel
    );
endinterface

// File: rtl/img2col_weight_pp.sv
// -----------------------------------------------------------------------------
// img2col_weight_pp
// Weight-side img2col engine. Reads chn_num kernels of kernel_size^2 words from
// one bank of the weight buffer, optionally in reversed (180 deg rotated) order
// inside each kernel, and mirrors every read as a write to the weight matrix
// buffer RD_LAT cycles later at the unrotated address.
// Ports:
//   clock  - rising-edge clock
//   rst    - synchronous active-high reset
//   bus    - img2col_weight_pp_if.slave (start/config in, status out,
//            buffer read strobe/address, matrix write strobe/address/data)
// -----------------------------------------------------------------------------
module img2col_weight_pp #(
    parameter int DATA_WID  = 16,
    parameter int BUF_DEPTH = 256,
    parameter int RD_LAT    = 2,
    parameter int AW        = $clog2(BUF_DEPTH)
) (
    input  logic                clock,
    input  logic                rst,
    img2col_weight_pp_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [15:0]   HALF_N    = 16'(BUF_DEPTH / 2);
    localparam logic [AW-1:0] BANK_BASE = AW'(BUF_DEPTH / 2);

    state_t          state_q, state_d;
    logic            cfg_sel_q, cfg_flip_q;
    logic [7:0]      cfg_chn_q;
    logic [3:0]      cfg_ks_q;
    logic [7:0]      ks2;
    logic [15:0]     n_total;
    logic            cfg_ok;
    logic            last_rd;
    logic            issue;
    logic [7:0]      k_q, k_d, p_q, p_d, drain_q;
    logic [AW-1:0]   kb_q, kb_d;
    logic [AW-1:0]   base, rd_addr_d, lin_addr_d;
    logic            rd_en_q, ready_q, done_q, err_q;
    logic [AW-1:0]   rd_addr_q, lin_addr_q;
    logic [RD_LAT-1:0] vld_p;
    logic [AW-1:0]   waddr_p [RD_LAT];

    assign ks2     = 8'(cfg_ks_q) * 8'(cfg_ks_q);
    assign n_total = 16'(cfg_chn_q) * 16'(ks2);
    assign cfg_ok  = cfg_ks_q[0] && (cfg_ks_q <= 4'd11) && (cfg_chn_q != 8'd0)
                     && (n_total <= HALF_N);
    assign last_rd = (k_q == cfg_chn_q - 8'd1) && (p_q == ks2 - 8'd1);
    assign base    = cfg_sel_q ? BANK_BASE : '0;

    // Counters here describe the read that will be presented next cycle.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        k_d     = k_q;
        p_d     = p_q;
        kb_d    = kb_q;
        unique case (state_q)
            S_IDLE: if (bus.i2c_wgt_start) state_d = S_LOAD;
            S_LOAD: begin
                if (cfg_ok) begin
                    state_d = S_RUN;
                    issue   = 1'b1;
                    k_d     = '0;
                    p_d     = '0;
                    kb_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_rd) begin
                    state_d = S_DRAIN;
                end else begin
                    issue = 1'b1;
                    if (p_q == ks2 - 8'd1) begin
                        p_d  = '0;
                        k_d  = k_q + 8'd1;
                        kb_d = kb_q + AW'(ks2);
                    end else begin
                        p_d = p_q + 8'd1;
                    end
                end
            end
            S_DRAIN: if (drain_q == 8'(RD_LAT - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Flipped offset ks2-1-p only affects the read side; writes stay linear.
    assign lin_addr_d = base + kb_d + AW'(p_d);
    assign rd_addr_d  = base + kb_d + AW'(cfg_flip_q ? (ks2 - 8'd1 - p_d) : p_d);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cfg_sel_q  <= 1'b0;
            cfg_flip_q <= 1'b0;
            cfg_chn_q  <= '0;
            cfg_ks_q   <= '0;
            k_q        <= '0;
            p_q        <= '0;
            kb_q       <= '0;
            drain_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            lin_addr_q <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            vld_p      <= '0;
            for (int i = 0; i < RD_LAT; i++) waddr_p[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.i2c_wgt_start) begin
                cfg_sel_q  <= bus.i2c_chn_sel;
                cfg_flip_q <= bus.flip;
                cfg_chn_q  <= bus.chn_num;
                cfg_ks_q   <= bus.kernel_size;
            end
            k_q     <= k_d;
            p_q     <= p_d;
            kb_q    <= kb_d;
            drain_q <= (state_q == S_DRAIN) ? drain_q + 8'd1 : 8'd0;
            ready_q <= (state_d == S_IDLE);
            done_q  <= (state_q == S_DRAIN) && (state_d == S_DONE);
            err_q   <= (state_q == S_LOAD) && !cfg_ok;
            // Read issue stage
            rd_en_q    <= issue;
            rd_addr_q  <= issue ? rd_addr_d : '0;
            lin_addr_q <= issue ? lin_addr_d : '0;
            // Write-side delay line, RD_LAT stages deep
            vld_p[0]   <= rd_en_q;
            waddr_p[0] <= lin_addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]   <= vld_p[i-1];
                waddr_p[i] <= waddr_p[i-1];
            end
        end
    end

    assign bus.i2c_ready   = ready_q;
    assign bus.i2c_done    = done_q;
    assign bus.i2c_err     = err_q;
    assign bus.wgt_rd_en   = rd_en_q;
    assign bus.wgt_rd_addr = rd_addr_q;
    assign bus.wgt_wr_en   = vld_p[RD_LAT-1];
    assign bus.wgt_wr_addr = waddr_p[RD_LAT-1];
    assign bus.wgt_out     = bus.wgt_in;
    assign bus.chn_sel     = cfg_sel_q;
endmodule

// File: tb/tb_img2col_weight_pp.sv
// -----------------------------------------------------------------------------
// tb_img2col_weight_pp
// Directed bench for img2col_weight_pp. A per-cycle timeline of expected reads,
// writes, data and status is built from each accepted configuration; one
// negedge process compares the DUT against it, and literal spot checks pin
// the timeline itself.
// -----------------------------------------------------------------------------
module tb_img2col_weight_pp;
    localparam int DATA_WID  = 16;
    localparam int BUF_DEPTH = 256;
    localparam int RD_LAT    = 2;
    localparam int AW        = 8;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    img2col_weight_pp_if #(.DATA_WID(DATA_WID), .AW(AW)) bus ();

    img2col_weight_pp #(
        .DATA_WID (DATA_WID),
        .BUF_DEPTH(BUF_DEPTH),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    int cyc      = 0;
    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;
    int exp_sel  = 0;
    int c0;

    int          exp_rd   [int];
    int          exp_wr   [int];
    int          exp_wd   [int];
    bit          exp_done [int];
    bit          exp_err  [int];
    bit          exp_busy [int];
    logic [15:0] data_at  [int];

    // Buffer contents: distinct word per address.
    function automatic int fdat(input int a);
        return (a * 37 + 4660) & 16'hFFFF;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic at(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 2000) begin
            tick(1);
            guard++;
        end
    endtask

    // Timeline from the functional rules: N reads from cycle c+2, writes RD_LAT
    // later at the linear address, done after the drain, busy in between.
    task automatic model_start(input int c, input int sel, input int chn,
                               input int ks, input bit fl);
        int ks2, n, base, ra, i;
        bit ok;
        ks2 = ks * ks;
        n   = chn * ks2;
        ok  = (ks % 2 == 1) && (ks <= 11) && (chn >= 1) && (n <= BUF_DEPTH / 2);
        exp_sel = sel;
        if (!ok) begin
            exp_busy[c+1] = 1'b1;
            exp_err[c+2]  = 1'b1;
            return;
        end
        base = sel ? BUF_DEPTH / 2 : 0;
        for (int k = 0; k < chn; k++) begin
            for (int p = 0; p < ks2; p++) begin
                i  = k * ks2 + p;
                ra = base + k * ks2 + (fl ? ks2 - 1 - p : p);
                exp_rd[c+2+i]        = ra;
                exp_wr[c+2+RD_LAT+i] = base + i;
                exp_wd[c+2+RD_LAT+i] = fdat(ra);
            end
        end
        for (int t = c + 1; t <= c + n + 2 + RD_LAT; t++) exp_busy[t] = 1'b1;
        exp_done[c+n+2+RD_LAT] = 1'b1;
    endtask

    task automatic model_reset(input int from);
        for (int t = from; t < from + 400; t++) begin
            if (exp_rd.exists(t))   exp_rd.delete(t);
            if (exp_wr.exists(t))   exp_wr.delete(t);
            if (exp_wd.exists(t))   exp_wd.delete(t);
            if (exp_done.exists(t)) exp_done.delete(t);
            if (exp_err.exists(t))  exp_err.delete(t);
            if (exp_busy.exists(t)) exp_busy.delete(t);
        end
    endtask

    task automatic run_op(input bit sel, input int chn, input int ks,
                          input bit fl, output int cs);
        bus.i2c_chn_sel   = sel;
        bus.chn_num       = 8'(chn);
        bus.kernel_size   = 4'(ks);
        bus.flip          = fl;
        bus.i2c_wgt_start = 1'b1;
        cs = cyc;
        model_start(cs, int'(sel), chn, ks, fl);
        tick(1);
        bus.i2c_wgt_start = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        bus.i2c_chn_sel   = sel;
        bus.i2c_wgt_start = 1'b1;
        tick(1);
        bus.i2c_wgt_start = 1'b0;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Weight buffer with RD_LAT read latency.
    always @(posedge clock) begin
        #1;
        bus.wgt_in = data_at.exists(cyc) ? data_at[cyc] : 16'h0;
    end

    always @(negedge clock) begin
        if (bus.i2c_done === 1'b1) done_cnt++;
        if (bus.wgt_rd_en === 1'b1) data_at[cyc+RD_LAT] = 16'(fdat(int'(bus.wgt_rd_addr)));
        if (chk_en) begin
            chk("rd_en", int'(bus.wgt_rd_en), int'(exp_rd.exists(cyc)));
            if (exp_rd.exists(cyc)) begin
                chk("rd_addr", int'(bus.wgt_rd_addr), exp_rd[cyc]);
                chk("chn_sel", int'(bus.chn_sel), exp_sel);
            end
            chk("wr_en", int'(bus.wgt_wr_en), int'(exp_wr.exists(cyc)));
            if (exp_wr.exists(cyc)) begin
                chk("wr_addr", int'(bus.wgt_wr_addr), exp_wr[cyc]);
                chk("wr_data", int'(bus.wgt_out), exp_wd[cyc]);
            end
            chk("passthru", int'(bus.wgt_out), int'(bus.wgt_in));
            chk("done", int'(bus.i2c_done), int'(exp_done.exists(cyc)));
            chk("err", int'(bus.i2c_err), int'(exp_err.exists(cyc)));
            chk("ready", int'(bus.i2c_ready), int'(!exp_busy.exists(cyc)));
        end
    end

    initial begin
        bus.i2c_wgt_start = 1'b0;
        bus.i2c_chn_sel   = 1'b0;
        bus.chn_num       = 8'd0;
        bus.kernel_size   = 4'd0;
        bus.flip          = 1'b0;
        bus.wgt_in        = 16'h0;
        rst = 1'b1;
        tick(3);
        chk("rst_ready", int'(bus.i2c_ready), 1);
        chk("rst_rd_en", int'(bus.wgt_rd_en), 0);
        chk("rst_wr_en", int'(bus.wgt_wr_en), 0);
        chk("rst_done", int'(bus.i2c_done), 0);
        chk("rst_err", int'(bus.i2c_err), 0);
        chk("rst_chn_sel", int'(bus.chn_sel), 0);
        chk("rst_rd_addr", int'(bus.wgt_rd_addr), 0);
        chk("rst_wr_addr", int'(bus.wgt_wr_addr), 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick(2);

        // ks=3, two kernels, bank 0, no flip
        run_op(1'b0, 2, 3, 1'b0, c0);
        at(c0 + 1);  chk("t1_ready_load", int'(bus.i2c_ready), 0);
        at(c0 + 2);  chk("t1_rd_first", int'(bus.wgt_rd_addr), 0);
                     chk("t1_rd_en_first", int'(bus.wgt_rd_en), 1);
        at(c0 + 19); chk("t1_rd_last", int'(bus.wgt_rd_addr), 17);
        at(c0 + 21); chk("t1_wr_last", int'(bus.wgt_wr_addr), 17);
                     chk("t1_wr_en_last", int'(bus.wgt_wr_en), 1);
        at(c0 + 22); chk("t1_done", int'(bus.i2c_done), 1);
        at(c0 + 26);

        // ks=3, one kernel, bank 1, flipped
        run_op(1'b1, 1, 3, 1'b1, c0);
        at(c0 + 2);  chk("t2_rd_first", int'(bus.wgt_rd_addr), 136);
        at(c0 + 4);  chk("t2_wr_first", int'(bus.wgt_wr_addr), 128);
        at(c0 + 5);  chk("t2_chn_sel", int'(bus.chn_sel), 1);
        at(c0 + 10); chk("t2_rd_last", int'(bus.wgt_rd_addr), 128);
        at(c0 + 12); chk("t2_wr_last", int'(bus.wgt_wr_addr), 136);
        at(c0 + 16);

        // ks=1, full bank 1
        run_op(1'b1, 128, 1, 1'b0, c0);
        at(c0 + 2);   chk("t3_rd_first", int'(bus.wgt_rd_addr), 128);
        at(c0 + 129); chk("t3_rd_last", int'(bus.wgt_rd_addr), 255);
        at(c0 + 132); chk("t3_done", int'(bus.i2c_done), 1);
        at(c0 + 136);

        // Illegal configurations
        run_op(1'b0, 1, 4, 1'b0, c0);
        at(c0 + 2); chk("ill_ks4_err", int'(bus.i2c_err), 1);
                    chk("ill_ks4_ready", int'(bus.i2c_ready), 1);
        at(c0 + 6);
        run_op(1'b0, 2, 11, 1'b0, c0);
        at(c0 + 2); chk("ill_big_err", int'(bus.i2c_err), 1);
                    chk("ill_big_ready", int'(bus.i2c_ready), 1);
        at(c0 + 6);
        run_op(1'b0, 0, 3, 1'b0, c0);
        at(c0 + 2); chk("ill_chn0_err", int'(bus.i2c_err), 1);
                    chk("ill_chn0_ready", int'(bus.i2c_ready), 1);
        at(c0 + 6);

        // Start pulses while busy are ignored
        run_op(1'b0, 2, 3, 1'b0, c0);
        at(c0 + 6);  pulse_start(1'b1);
        at(c0 + 22); pulse_start(1'b1);
        at(c0 + 28);

        // Reset in the middle of RUN, then a clean rerun
        run_op(1'b0, 2, 3, 1'b0, c0);
        at(c0 + 6);
        rst = 1'b1;
        model_reset(c0 + 7);
        tick(1);
        chk("mid_rst_ready", int'(bus.i2c_ready), 1);
        chk("mid_rst_rd_en", int'(bus.wgt_rd_en), 0);
        chk("mid_rst_wr_en", int'(bus.wgt_wr_en), 0);
        rst = 1'b0;
        at(c0 + 12);
        run_op(1'b0, 2, 3, 1'b0, c0);
        at(c0 + 2);  chk("rerun_rd_first", int'(bus.wgt_rd_addr), 0);
        at(c0 + 22); chk("rerun_done", int'(bus.i2c_done), 1);
        at(c0 + 26);

        chk("done_count", done_cnt, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
